conv_stream_seq: RTL

- Parametrised phase sequencer for the UART image-convolution datapath.
- Parses the incoming byte stream in order: sync byte, then kernel bytes, then pixel bytes.
- Drives kernel-register writes and pixel pushes into the convolution engine, tags each pixel with row/column/channel, and flags valid output windows.
- Buffers engine results in a small FIFO and drains them to the UART transmitter under a busy handshake. Exposes status LEDs.

---
 rtl/conv_pkg.sv | 28 ++
 rtl/conv_stream_seq_fifo.sv | 56 +++++
 rtl/conv_stream_seq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared state encoding, default sync byte and width helpers for the
// convolution stream sequencer.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_KERNEL,
        ST_PIXEL,
        ST_DRAIN
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Index width for a range of n values; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int kern_bytes(input int ksize, input int ch);
        return ksize * ksize * ch;
    endfunction

    function automatic int exp_results(input int img_w, input int img_h,
                                       input int ksize, input int ch);
        return (img_w - ksize + 1) * (img_h - ksize + 1) * ch;
    endfunction

endpackage

// File: rtl/conv_stream_seq_fifo.sv
// Result FIFO between the convolution engine and the UART transmitter.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module conv_res_fifo
    import conv_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic         ovf
);
    localparam int AW = idx_w(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        full     = (cnt_q == CW'(DEPTH));
        empty    = (cnt_q == '0);
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        ovf      = push & full & ~do_pop;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
        dout     = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/conv_stream_seq.sv
// Phase sequencer for the UART convolution datapath: sync, kernel, pixels, drain.
// Optional CONV_SYNC_CHECK_EN: reject a first byte other than SYNC_BYTE (sets err).
module conv_stream_seq
    import conv_pkg::*;
#(
    parameter int         IMG_W      = 502,
    parameter int         IMG_H      = 502,
    parameter int         CH         = 3,
    parameter int         KSIZE      = 3,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     rx_valid,
    input  logic [7:0]                               rx_data,
    output logic                                     kern_we,
    output logic [idx_w(kern_bytes(KSIZE, CH))-1:0]  kern_idx,
    output logic [7:0]                               kern_data,
    output logic                                     pix_we,
    output logic [7:0]                               pix_data,
    output logic [idx_w(CH)-1:0]                     pix_ch,
    output logic [idx_w(IMG_W)-1:0]                  pix_col,
    output logic [idx_w(IMG_H)-1:0]                  pix_row,
    output logic                                     win_valid,
    input  logic                                     res_valid,
    input  logic [7:0]                               res_data,
    input  logic                                     tx_busy,
    output logic                                     tx_start,
    output logic [7:0]                               tx_data,
    output logic                                     led_kernel,
    output logic                                     led_frame,
    output logic                                     err
);
    localparam int KBYTES = kern_bytes(KSIZE, CH);
    localparam int EXP    = exp_results(IMG_W, IMG_H, KSIZE, CH);
    localparam int KIW    = idx_w(KBYTES);
    localparam int CHW    = idx_w(CH);
    localparam int COLW   = idx_w(IMG_W);
    localparam int ROWW   = idx_w(IMG_H);
    localparam int SW     = idx_w(EXP + 1);

    state_e          state_q, state_d;
    logic [KIW-1:0]  kcnt_q, kcnt_d, kern_idx_q, kern_idx_d;
    logic [CHW-1:0]  ch_q, ch_d, pix_ch_q, pix_ch_d;
    logic [COLW-1:0] col_q, col_d, pix_col_q, pix_col_d;
    logic [ROWW-1:0] row_q, row_d, pix_row_q, pix_row_d;
    logic [SW-1:0]   sent_q, sent_d;
    logic [7:0]      kern_data_q, kern_data_d, pix_data_q, pix_data_d, tx_data_q, tx_data_d;
    logic            kern_we_q, kern_we_d, pix_we_q, pix_we_d, win_valid_q, win_valid_d;
    logic            tx_start_q, tx_start_d;
    logic            led_kernel_q, led_kernel_d, led_frame_q, led_frame_d, err_q, err_d;
    logic            ch_last, col_last, row_last;
    logic            fifo_full, fifo_empty, fifo_ovf;
    logic [7:0]      fifo_dout;

    conv_res_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (res_valid),
        .din   (res_data),
        .pop   (tx_start_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .ovf   (fifo_ovf)
    );

    always_comb begin
        ch_last      = (ch_q == CHW'(CH - 1));
        col_last     = (col_q == COLW'(IMG_W - 1));
        row_last     = (row_q == ROWW'(IMG_H - 1));
        state_d      = state_q;
        kcnt_d       = kcnt_q;
        ch_d         = ch_q;
        col_d        = col_q;
        row_d        = row_q;
        sent_d       = sent_q + SW'(tx_start_q);
        kern_we_d    = 1'b0;
        kern_idx_d   = kern_idx_q;
        kern_data_d  = kern_data_q;
        pix_we_d     = 1'b0;
        win_valid_d  = 1'b0;
        pix_data_d   = pix_data_q;
        pix_ch_d     = pix_ch_q;
        pix_col_d    = pix_col_q;
        pix_row_d    = pix_row_q;
        // The previous-cycle guard also keeps a new request off the pop cycle.
        tx_start_d   = ~fifo_empty & ~tx_busy & ~tx_start_q;
        tx_data_d    = tx_start_d ? fifo_dout : tx_data_q;
        led_kernel_d = led_kernel_q;
        led_frame_d  = led_frame_q;
        err_d        = err_q | fifo_ovf;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
`ifdef CONV_SYNC_CHECK_EN
                    if (rx_data == SYNC_BYTE) state_d = ST_KERNEL;
                    else                      err_d   = 1'b1;
`else
                    state_d = ST_KERNEL;
`endif
                end
            end
            ST_KERNEL: begin
                if (rx_valid) begin
                    kern_we_d   = 1'b1;
                    kern_idx_d  = kcnt_q;
                    kern_data_d = rx_data;
                    if (kcnt_q == KIW'(KBYTES - 1)) begin
                        kcnt_d       = '0;
                        led_kernel_d = 1'b1;
                        state_d      = ST_PIXEL;
                    end else begin
                        kcnt_d = kcnt_q + 1'b1;
                    end
                end
            end
            ST_PIXEL: begin
                if (rx_valid) begin
                    pix_we_d    = 1'b1;
                    pix_data_d  = rx_data;
                    pix_ch_d    = ch_q;
                    pix_col_d   = col_q;
                    pix_row_d   = row_q;
                    win_valid_d = (col_q >= COLW'(KSIZE - 1)) && (row_q >= ROWW'(KSIZE - 1));
                    ch_d        = ch_last ? '0 : ch_q + 1'b1;
                    if (ch_last) begin
                        col_d = col_last ? '0 : col_q + 1'b1;
                        if (col_last) row_d = row_last ? '0 : row_q + 1'b1;
                    end
                    if (ch_last && col_last && row_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (sent_q == SW'(EXP) && fifo_empty) begin
                    led_frame_d = 1'b1;
                    kcnt_d      = '0;
                    ch_d        = '0;
                    col_d       = '0;
                    row_d       = '0;
                    sent_d      = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            kcnt_q       <= '0;
            ch_q         <= '0;
            col_q        <= '0;
            row_q        <= '0;
            sent_q       <= '0;
            kern_we_q    <= 1'b0;
            kern_idx_q   <= '0;
            kern_data_q  <= '0;
            pix_we_q     <= 1'b0;
            win_valid_q  <= 1'b0;
            pix_data_q   <= '0;
            pix_ch_q     <= '0;
            pix_col_q    <= '0;
            pix_row_q    <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            led_kernel_q <= 1'b0;
            led_frame_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            kcnt_q       <= kcnt_d;
            ch_q         <= ch_d;
            col_q        <= col_d;
            row_q        <= row_d;
            sent_q       <= sent_d;
            kern_we_q    <= kern_we_d;
            kern_idx_q   <= kern_idx_d;
            kern_data_q  <= kern_data_d;
            pix_we_q     <= pix_we_d;
            win_valid_q  <= win_valid_d;
            pix_data_q   <= pix_data_d;
            pix_ch_q     <= pix_ch_d;
            pix_col_q    <= pix_col_d;
            pix_row_q    <= pix_row_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            led_kernel_q <= led_kernel_d;
            led_frame_q  <= led_frame_d;
            err_q        <= err_d;
        end
    end

    assign kern_we    = kern_we_q;
    assign kern_idx   = kern_idx_q;
    assign kern_data  = kern_data_q;
    assign pix_we     = pix_we_q;
    assign pix_data   = pix_data_q;
    assign pix_ch     = pix_ch_q;
    assign pix_col    = pix_col_q;
    assign pix_row    = pix_row_q;
    assign win_valid  = win_valid_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign led_kernel = led_kernel_q;
    assign led_frame  = led_frame_q;
    assign err        = err_q;

endmodule
